year_counter_bcd: RTL and testbench

//  Parametrised year register for the calendar chain. It holds the year in packed BCD and

---
 rtl/year_counter_bcd_if.sv | 33 +++
 rtl/year_counter_bcd.sv | 263 ++++++++++++++++++++++++++
 tb/tb_year_counter_bcd.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/year_counter_bcd_if.sv
// Purpose: control and display bundle of the year counter.
//   enable/set_mode/abort/inc/dec/step_sel  : controller -> counter
//   year_bcd/year_bin/disp_bcd/leap_year/
//   wrap/in_set/committed                   : counter -> consumers
interface year_counter_bcd_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned SEL_W  = 2
);
  logic                  enable;
  logic                  set_mode;
  logic                  abort;
  logic                  inc;
  logic                  dec;
  logic [SEL_W-1:0]      step_sel;
  logic [4*DIGITS-1:0]   year_bcd;
  logic [BIN_W-1:0]      year_bin;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  leap_year;
  logic                  wrap;
  logic                  in_set;
  logic                  committed;

  modport master (
    output enable, set_mode, abort, inc, dec, step_sel,
    input  year_bcd, year_bin, disp_bcd, leap_year, wrap, in_set, committed
  );

  modport slave (
    input  enable, set_mode, abort, inc, dec, step_sel,
    output year_bcd, year_bin, disp_bcd, leap_year, wrap, in_set, committed
  );
endinterface

// File: rtl/year_counter_bcd.sv
// Purpose: year register (BCD + binary) advanced by the yearly carry, with a
// shadow edit mode (decade inc/dec, commit, abort) and Gregorian leap flag.
// Ports: clk_1s, rst (async, active-high), bus (year_counter_bcd_if.slave).
module year_counter_bcd #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned YEAR_MIN = 2025,
  parameter int unsigned YEAR_MAX = 2999,
  parameter int unsigned YEAR_RST = 2025,
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned SEL_W    = 2
) (
  input  logic               clk_1s,
  input  logic               rst,
  year_counter_bcd_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;

  // Elaboration-time conversion of the year constants to packed BCD.
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    int unsigned r;
    logic [BCD_W-1:0] res;
    r   = v;
    res = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  localparam logic [BCD_W-1:0] MIN_BCD = to_bcd(YEAR_MIN);
  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(YEAR_MAX);
  localparam logic [BCD_W-1:0] RST_BCD = to_bcd(YEAR_RST);

  typedef enum logic [1:0] {ST_RUN, ST_SET, ST_COMMIT} state_t;

  // 10**e as a constant-table mux.
  function automatic int unsigned pow10(input int unsigned e);
    int unsigned k;
    int unsigned p;
    k = 1;
    p = 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i == e) p = k;
      k = k * 10;
    end
    return p;
  endfunction

  // Add one at digit pos with decimal carry ripple.
  function automatic logic [BCD_W-1:0] bcd_add(input logic [BCD_W-1:0] v, input int unsigned pos);
    logic [BCD_W-1:0] r;
    logic [4:0]       s;
    logic             c;
    r = '0;
    c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      s = {1'b0, v[4*i +: 4]} + {4'd0, (i == pos)} + {4'd0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // Subtract one at digit pos with decimal borrow ripple.
  function automatic logic [BCD_W-1:0] bcd_sub(input logic [BCD_W-1:0] v, input int unsigned pos);
    logic [BCD_W-1:0] r;
    logic [4:0]       s;
    logic             b;
    r = '0;
    b = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      s = {1'b0, v[4*i +: 4]} - {4'd0, (i == pos)} - {4'd0, b};
      if (s[4]) begin
        r[4*i +: 4] = 4'(s + 5'd10);
        b = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        b = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit(input logic [BCD_W-1:0] v, input int unsigned idx);
    logic [3:0] d;
    d = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i == idx) d = v[4*i +: 4];
    end
    return d;
  endfunction

  // Two-digit divisible-by-4 test on BCD tens/units.
  function automatic logic div4(input logic [3:0] tens, input logic [3:0] units);
    if (tens[0]) return (units == 4'd2) || (units == 4'd6);
    return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
  endfunction

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   live_bcd_q, live_bcd_d;
  logic [BIN_W-1:0]   live_bin_q, live_bin_d;
  logic [BCD_W-1:0]   shd_bcd_q, shd_bcd_d;
  logic [BIN_W-1:0]   shd_bin_q, shd_bin_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               inc_q, inc_d, dec_q, dec_d;
  logic               wrap_q, wrap_d;
  logic               in_set_q, in_set_d;
  logic               committed_q, committed_d;

  logic               inc_rise, dec_rise;
  int unsigned        sel_e, step;
  logic [BCD_W-1:0]   live_nx_bcd, shd_nx_bcd, shd_up_bcd, shd_dn_bcd;
  logic [BIN_W-1:0]   live_nx_bin, shd_nx_bin, shd_up_bin, shd_dn_bin;
  logic               live_wraps, shd_wraps;

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    live_bcd_d  = live_bcd_q;
    live_bin_d  = live_bin_q;
    shd_bcd_d   = shd_bcd_q;
    shd_bin_d   = shd_bin_q;
    inc_d       = bus.inc;
    dec_d       = bus.dec;
    wrap_d      = 1'b0;

    inc_rise = bus.inc & ~inc_q;
    dec_rise = bus.dec & ~dec_q;
    sel_e    = (32'(bus.step_sel) < DIGITS) ? 32'(bus.step_sel) : 32'd0;
    step     = pow10(sel_e);

    live_wraps = (live_bin_q == BIN_W'(YEAR_MAX));
    if (live_wraps) begin
      live_nx_bcd = MIN_BCD;
      live_nx_bin = BIN_W'(YEAR_MIN);
    end else begin
      live_nx_bcd = bcd_add(live_bcd_q, 0);
      live_nx_bin = live_bin_q + BIN_W'(1);
    end

    shd_wraps = (shd_bin_q == BIN_W'(YEAR_MAX));
    if (shd_wraps) begin
      shd_nx_bcd = MIN_BCD;
      shd_nx_bin = BIN_W'(YEAR_MIN);
    end else begin
      shd_nx_bcd = bcd_add(shd_bcd_q, 0);
      shd_nx_bin = shd_bin_q + BIN_W'(1);
    end

    if (32'(shd_bin_q) + step > YEAR_MAX) begin
      shd_up_bcd = MIN_BCD;
      shd_up_bin = BIN_W'(YEAR_MIN);
    end else begin
      shd_up_bcd = bcd_add(shd_bcd_q, sel_e);
      shd_up_bin = BIN_W'(32'(shd_bin_q) + step);
    end

    if (32'(shd_bin_q) < YEAR_MIN + step) begin
      shd_dn_bcd = MAX_BCD;
      shd_dn_bin = BIN_W'(YEAR_MAX);
    end else begin
      shd_dn_bcd = bcd_sub(shd_bcd_q, sel_e);
      shd_dn_bin = BIN_W'(32'(shd_bin_q) - step);
    end

    if (bus.enable) begin
      live_bcd_d = live_nx_bcd;
      live_bin_d = live_nx_bin;
      wrap_d     = live_wraps;
    end

    case (state_q)
      ST_RUN: begin
        if (bus.set_mode) begin
          state_d   = ST_SET;
          shd_bcd_d = live_bcd_q;
          shd_bin_d = live_bin_q;
        end
      end
      ST_SET: begin
        if (bus.abort) begin
          state_d = ST_RUN;
        end else if (!bus.set_mode) begin
          // Live is loaded on the SET exit edge so the COMMIT cycle shows it.
          state_d = ST_COMMIT;
          if (bus.enable) begin
            live_bcd_d = shd_nx_bcd;
            live_bin_d = shd_nx_bin;
            wrap_d     = shd_wraps;
          end else begin
            live_bcd_d = shd_bcd_q;
            live_bin_d = shd_bin_q;
            wrap_d     = 1'b0;
          end
        end else if (inc_rise && !dec_rise) begin
          shd_bcd_d = shd_up_bcd;
          shd_bin_d = shd_up_bin;
        end else if (dec_rise && !inc_rise) begin
          shd_bcd_d = shd_dn_bcd;
          shd_bin_d = shd_dn_bin;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    in_set_d    = (state_d == ST_SET);
    committed_d = (state_d == ST_COMMIT);
    disp_d      = in_set_d ? shd_bcd_d : live_bcd_d;
  end

  // State registers.
  always_ff @(posedge clk_1s or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      live_bcd_q  <= RST_BCD;
      live_bin_q  <= BIN_W'(YEAR_RST);
      shd_bcd_q   <= RST_BCD;
      shd_bin_q   <= BIN_W'(YEAR_RST);
      disp_q      <= RST_BCD;
      inc_q       <= 1'b1;
      dec_q       <= 1'b1;
      wrap_q      <= 1'b0;
      in_set_q    <= 1'b0;
      committed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_bcd_q  <= live_bcd_d;
      live_bin_q  <= live_bin_d;
      shd_bcd_q   <= shd_bcd_d;
      shd_bin_q   <= shd_bin_d;
      disp_q      <= disp_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      wrap_q      <= wrap_d;
      in_set_q    <= in_set_d;
      committed_q <= committed_d;
    end
  end

  logic [3:0] d0, d1, d2, d3;
  assign d0 = digit(live_bcd_q, 0);
  assign d1 = digit(live_bcd_q, 1);
  assign d2 = digit(live_bcd_q, 2);
  assign d3 = digit(live_bcd_q, 3);

  // Century years fall back to the upper two digits (/400 rule).
  assign bus.leap_year = ((d1 == 4'd0) && (d0 == 4'd0)) ? div4(d3, d2) : div4(d1, d0);
  assign bus.year_bcd  = live_bcd_q;
  assign bus.year_bin  = live_bin_q;
  assign bus.disp_bcd  = disp_q;
  assign bus.wrap      = wrap_q;
  assign bus.in_set    = in_set_q;
  assign bus.committed = committed_q;

endmodule

// File: tb/tb_year_counter_bcd.sv
// Purpose: directed self-checking bench for year_counter_bcd.
module tb_year_counter_bcd;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  year_counter_bcd_if #(.DIGITS(4), .BIN_W(14), .SEL_W(2)) bus ();

  year_counter_bcd #(
    .DIGITS(4), .YEAR_MIN(2025), .YEAR_MAX(2999), .YEAR_RST(2025), .BIN_W(14), .SEL_W(2)
  ) dut (
    .clk_1s (clk),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press_inc(input logic [1:0] sel);
    bus.step_sel = sel;
    bus.inc = 1'b1;
    tick();
    bus.inc = 1'b0;
    tick();
  endtask

  task automatic press_dec(input logic [1:0] sel);
    bus.step_sel = sel;
    bus.dec = 1'b1;
    tick();
    bus.dec = 1'b0;
    tick();
  endtask

  task automatic pulse_enable();
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    tick();
  endtask

  task automatic commit_edit();
    bus.set_mode = 1'b0;
    tick();
    chk("commit_pulse", 32'(bus.committed), 32'd1);
    tick();
    chk("commit_done", 32'(bus.committed), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0; bus.set_mode = 1'b0; bus.abort = 1'b0;
    bus.inc = 1'b0; bus.dec = 1'b0; bus.step_sel = 2'd0;
    tick(); tick();
    rst = 1'b0;

    // 1. reset state
    chk("rst_bcd", 32'(bus.year_bcd), 32'h2025);
    chk("rst_bin", 32'(bus.year_bin), 32'd2025);
    chk("rst_leap", 32'(bus.leap_year), 32'd0);
    chk("rst_in_set", 32'(bus.in_set), 32'd0);
    chk("rst_disp", 32'(bus.disp_bcd), 32'h2025);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);
    chk("rst_committed", 32'(bus.committed), 32'd0);

    // 2. load 2999, wrap on enable, walk leap years
    bus.set_mode = 1'b1;
    tick();
    chk("set_entry", 32'(bus.in_set), 32'd1);
    press_dec(2'd0);
    chk("dec_unit_wrap", 32'(bus.disp_bcd), 32'h2999);
    commit_edit();
    chk("load_2999_bcd", 32'(bus.year_bcd), 32'h2999);
    chk("load_2999_bin", 32'(bus.year_bin), 32'd2999);
    bus.enable = 1'b1;
    tick();
    chk("wrap_bcd", 32'(bus.year_bcd), 32'h2025);
    chk("wrap_pulse", 32'(bus.wrap), 32'd1);
    bus.enable = 1'b0;
    tick();
    chk("wrap_clear", 32'(bus.wrap), 32'd0);
    chk("wrap_disp", 32'(bus.disp_bcd), 32'h2025);
    pulse_enable(); pulse_enable(); pulse_enable();
    chk("walk_2028_bcd", 32'(bus.year_bcd), 32'h2028);
    chk("walk_2028_bin", 32'(bus.year_bin), 32'd2028);
    chk("leap_2028", 32'(bus.leap_year), 32'd1);
    bus.set_mode = 1'b1;
    tick();
    press_inc(2'd2);
    chk("inc_hund", 32'(bus.disp_bcd), 32'h2128);
    press_dec(2'd1); press_dec(2'd1); press_dec(2'd1);
    chk("dec_tens_borrow", 32'(bus.disp_bcd), 32'h2098);
    press_inc(2'd0); press_inc(2'd0);
    chk("inc_unit_carry", 32'(bus.disp_bcd), 32'h2100);
    commit_edit();
    chk("y2100_bcd", 32'(bus.year_bcd), 32'h2100);
    chk("leap_2100", 32'(bus.leap_year), 32'd0);
    bus.set_mode = 1'b1;
    tick();
    press_inc(2'd2); press_inc(2'd2); press_inc(2'd2);
    commit_edit();
    chk("y2400_bin", 32'(bus.year_bin), 32'd2400);
    chk("leap_2400", 32'(bus.leap_year), 32'd1);

    // 3. held inc gives one step; dec underflow wraps to max
    do_reset();
    bus.set_mode = 1'b1;
    tick();
    bus.step_sel = 2'd2;
    bus.inc = 1'b1;
    repeat (5) tick();
    chk("held_inc", 32'(bus.disp_bcd), 32'h2125);
    bus.inc = 1'b0;
    tick();
    chk("held_inc_live", 32'(bus.year_bcd), 32'h2025);
    press_dec(2'd2);
    chk("dec_hund", 32'(bus.disp_bcd), 32'h2025);
    press_dec(2'd2);
    chk("dec_underflow", 32'(bus.disp_bcd), 32'h2999);

    // 4. live counts in SET; commit coincident with enable
    repeat (5) pulse_enable();
    chk("set_live_2030", 32'(bus.year_bcd), 32'h2030);
    chk("set_still_in", 32'(bus.in_set), 32'd1);
    repeat (5) press_dec(2'd2);
    press_inc(2'd0);
    chk("shadow_2500", 32'(bus.disp_bcd), 32'h2500);
    bus.set_mode = 1'b0;
    bus.enable = 1'b1;
    tick();
    chk("commit_en_pulse", 32'(bus.committed), 32'd1);
    chk("commit_en_bcd", 32'(bus.year_bcd), 32'h2501);
    chk("commit_en_bin", 32'(bus.year_bin), 32'd2501);
    chk("commit_en_wrap", 32'(bus.wrap), 32'd0);
    bus.enable = 1'b0;
    tick();
    chk("commit_en_after", 32'(bus.committed), 32'd0);
    chk("commit_en_hold", 32'(bus.year_bcd), 32'h2501);

    // 5. RUN ignores inc; abort discards shadow; inc+dec together is a no-op
    do_reset();
    repeat (5) pulse_enable();
    press_inc(2'd0);
    chk("run_inc_ignored", 32'(bus.year_bcd), 32'h2030);
    chk("run_disp", 32'(bus.disp_bcd), 32'h2030);
    bus.set_mode = 1'b1;
    tick();
    repeat (7) press_inc(2'd2);
    repeat (3) press_dec(2'd1);
    chk("shadow_2700", 32'(bus.disp_bcd), 32'h2700);
    pulse_enable(); pulse_enable();
    chk("abort_live_2032", 32'(bus.year_bcd), 32'h2032);
    chk("abort_disp_shadow", 32'(bus.disp_bcd), 32'h2700);
    bus.step_sel = 2'd0;
    bus.inc = 1'b1; bus.dec = 1'b1;
    tick();
    chk("inc_dec_same", 32'(bus.disp_bcd), 32'h2700);
    bus.inc = 1'b0; bus.dec = 1'b0;
    tick();
    bus.abort = 1'b1;
    bus.set_mode = 1'b0;
    tick();
    chk("abort_in_set", 32'(bus.in_set), 32'd0);
    chk("abort_no_commit", 32'(bus.committed), 32'd0);
    chk("abort_live", 32'(bus.year_bcd), 32'h2032);
    chk("abort_disp", 32'(bus.disp_bcd), 32'h2032);
    bus.abort = 1'b0;
    tick();
    chk("abort_no_commit2", 32'(bus.committed), 32'd0);

    // 6. asynchronous reset mid-SET
    bus.set_mode = 1'b1;
    tick();
    press_inc(2'd1);
    chk("pre_rst_disp", 32'(bus.disp_bcd), 32'h2042);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_set", 32'(bus.in_set), 32'd0);
    chk("arst_bcd", 32'(bus.year_bcd), 32'h2025);
    chk("arst_disp", 32'(bus.disp_bcd), 32'h2025);
    bus.inc = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_set", 32'(bus.in_set), 32'd1);
    tick();
    chk("held_through_rst", 32'(bus.disp_bcd), 32'h2025);
    bus.inc = 1'b0;
    commit_edit();
    chk("post_rst_run", 32'(bus.in_set), 32'd0);
    chk("post_rst_bcd", 32'(bus.year_bcd), 32'h2025);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
